// File: rtl/nios_core_pio_pkg.sv
// Shared register map and PWM constants for the nios_core_pio output block family.
package nios_core_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MODE     = 3'd1;
  localparam logic [2:0] ADDR_DUTY     = 3'd2;
  localparam logic [2:0] ADDR_PRESCALE = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
  localparam logic [2:0] ADDR_TOGGLE   = 3'd6;
  localparam logic [2:0] ADDR_STATUS   = 3'd7;

  localparam int unsigned DUTY_W = 8;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 8'hFF;
  // PWM counter runs 0..254 so DUTY=255 can mean "always on".
  localparam logic [DUTY_W-1:0] PWM_LAST = 8'd254;

endpackage

// File: rtl/nios_core_pio_prescaler.sv
// Blink prescaler: counts 0..limit and toggles phase on each wrap; load restarts the count.
module nios_core_pio_prescaler #(
  parameter int unsigned PRESCALE_W = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [PRESCALE_W-1:0] limit,
  output logic                  phase
);

  logic [PRESCALE_W-1:0] r_cnt;
  logic                  r_phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (load) begin
      r_cnt <= '0;
    end else if (r_cnt == limit) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign phase = r_phase;

endmodule

// File: rtl/nios_core_pio_out_fx.sv
// Avalon-MM PIO output block with per-bit blink and optional global PWM dimming.
// Optional feature: define NIOS_CORE_PIO_PWM_EN to build the DUTY register and PWM gating.
module nios_core_pio_out_fx
  import nios_core_pio_pkg::*;
#(
  parameter int unsigned     WIDTH       = 16,
  parameter int unsigned     PRESCALE_W  = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic                  w_wr;
  logic [WIDTH-1:0]      w_wdata;
  logic [WIDTH-1:0]      w_data_d;
  logic [WIDTH-1:0]      w_out_d;
  logic                  w_presc_load;
  logic                  w_phase;
  logic                  w_pwm_on;
  logic [31:0]           w_duty_rd;
  logic                  w_unused_wdata;

  logic [WIDTH-1:0]      r_data;
  logic [WIDTH-1:0]      r_mode;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [WIDTH-1:0]      r_out;

  assign w_wr           = chipselect & ~write_n;
  assign w_wdata        = writedata[WIDTH-1:0];
  assign w_presc_load   = w_wr && (address == ADDR_PRESCALE);
  assign w_unused_wdata = ^writedata;

  always_comb begin
    w_data_d = r_data;
    if (w_wr) begin
      case (address)
        ADDR_DATA:     w_data_d = w_wdata;
        ADDR_OUTSET:   w_data_d = r_data | w_wdata;
        ADDR_OUTCLEAR: w_data_d = r_data & ~w_wdata;
        ADDR_TOGGLE:   w_data_d = r_data ^ w_wdata;
        default:       w_data_d = r_data;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data     <= RESET_VALUE;
      r_mode     <= '0;
      r_prescale <= '1;
    end else begin
      r_data <= w_data_d;
      if (w_wr && (address == ADDR_MODE)) r_mode <= w_wdata;
      if (w_presc_load) r_prescale <= writedata[PRESCALE_W-1:0];
    end
  end

  nios_core_pio_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (w_presc_load),
    .limit  (r_prescale),
    .phase  (w_phase)
  );

`ifdef NIOS_CORE_PIO_PWM_EN
  logic [DUTY_W-1:0] r_duty;
  logic [DUTY_W-1:0] r_pwm_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_duty    <= DUTY_MAX;
      r_pwm_cnt <= '0;
    end else begin
      if (w_wr && (address == ADDR_DUTY)) r_duty <= writedata[DUTY_W-1:0];
      r_pwm_cnt <= (r_pwm_cnt == PWM_LAST) ? '0 : r_pwm_cnt + 1'b1;
    end
  end

  assign w_pwm_on  = (r_duty == DUTY_MAX) | (r_pwm_cnt < r_duty);
  assign w_duty_rd = 32'(r_duty);
`else
  assign w_pwm_on  = 1'b1;
  assign w_duty_rd = '0;
`endif

  // Blink-mode bits follow the phase; all bits are gated by the PWM.
  assign w_out_d = r_data & (~r_mode | {WIDTH{w_phase}}) & {WIDTH{w_pwm_on}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out <= RESET_VALUE;
    end else begin
      r_out <= w_out_d;
    end
  end

  assign out_port = r_out;

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:     readdata = 32'(r_data);
      ADDR_MODE:     readdata = 32'(r_mode);
      ADDR_DUTY:     readdata = w_duty_rd;
      ADDR_PRESCALE: readdata = 32'(r_prescale);
      ADDR_STATUS:   readdata = {30'b0, w_pwm_on, w_phase};
      default:       readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_nios_core_pio_out_fx.sv
// Scoreboard bench for nios_core_pio_out_fx; covers PWM or non-PWM build per NIOS_CORE_PIO_PWM_EN.
module tb_nios_core_pio_out_fx;
  import nios_core_pio_pkg::*;

  localparam logic [15:0] RV = 16'h00A5;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b1;
  logic [2:0]  address    = '0;
  logic        chipselect = 1'b0;
  logic        write_n    = 1'b1;
  logic [31:0] writedata  = '0;
  logic [31:0] readdata;
  logic [15:0] out_port;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [15:0] m_out;

  nios_core_pio_out_fx #(
    .WIDTH      (16),
    .PRESCALE_W (24),
    .RESET_VALUE(RV)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, want %08h", tag, act, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [31:0] act);
    logic [31:0] e;
    e = 'x;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    check_eq(tag, act, e);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    address = a;
    exp_q.push_back(exp);
    #1;
    sb_check(tag, readdata);
  endtask

  // Write, then confirm out_port holds the old value on the write edge and the new one an edge later.
  task automatic write_out(input logic [2:0] a, input logic [31:0] d, input logic [15:0] new_out,
                           input string tag);
    bus_write(a, d);
    check_eq({tag, " hold"}, 32'(out_port), 32'(m_out));
    exp_q.push_back(32'(new_out));
    @(posedge clk);
    #1;
    sb_check({tag, " out"}, 32'(out_port));
    m_out = new_out;
  endtask

  task automatic count_cycles(input int n, output int hi, output int lo);
    hi = 0;
    lo = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (out_port == 16'hFFFF) hi++;
      if (out_port == 16'h0000) lo++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int lo;

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    check_eq("reset out_port", 32'(out_port), 32'(RV));
    address = ADDR_DATA;
    #1;
    check_eq("reset DATA", readdata, 32'h0000_00A5);
`ifdef NIOS_CORE_PIO_PWM_EN
    address = ADDR_DUTY;
    #1;
    check_eq("reset DUTY", readdata, 32'h0000_00FF);
`endif
    address = ADDR_PRESCALE;
    #1;
    check_eq("reset PRESCALE", readdata, 32'h00FF_FFFF);
    address = ADDR_STATUS;
    #1;
    check_eq("reset STATUS", readdata, 32'h2);
    #20;
    @(negedge clk);
    reset_n = 1'b1;
    m_out   = RV;
    repeat (2) @(posedge clk);
    #1;
    check_eq("post-reset out_port", 32'(out_port), 32'(RV));
    bus_read(ADDR_MODE, 32'h0, "reset MODE");

    // Set/clear/toggle sequence
    write_out(ADDR_DATA,     32'h0000_00F0, 16'h00F0, "DATA wr");
    write_out(ADDR_OUTSET,   32'h0000_000F, 16'h00FF, "OUTSET");
    write_out(ADDR_OUTCLEAR, 32'h0000_0030, 16'h00CF, "OUTCLEAR");
    write_out(ADDR_TOGGLE,   32'h0000_0101, 16'h01CE, "TOGGLE");
    write_out(ADDR_OUTSET,   32'h0,         16'h01CE, "OUTSET zero");
    write_out(ADDR_OUTCLEAR, 32'h0,         16'h01CE, "OUTCLEAR zero");
    write_out(ADDR_TOGGLE,   32'h0,         16'h01CE, "TOGGLE zero");
    bus_read(ADDR_DATA, 32'h0000_01CE, "DATA readback");
    bus_read(ADDR_OUTSET, 32'h0, "read OUTSET");
    bus_read(ADDR_OUTCLEAR, 32'h0, "read OUTCLEAR");
    bus_read(ADDR_TOGGLE, 32'h0, "read TOGGLE");
    bus_write(ADDR_STATUS, 32'hFFFF_FFFF);
    bus_read(ADDR_STATUS, 32'h2, "STATUS after write");

    // Blink: prescale written on E0, phase toggles on E4, E8, ...
    bus_write(ADDR_PRESCALE, 32'h3);
    bus_write(ADDR_MODE, 32'h1);
    bus_write(ADDR_DATA, 32'h1);
    address = ADDR_STATUS;
    for (int n = 3; n <= 26; n++) begin
      @(posedge clk);
      #1;
      exp_q.push_back((((n - 1) / 4) % 2 == 1) ? 32'h1 : 32'h0);
      sb_check($sformatf("blink out n=%0d", n), 32'(out_port));
      exp_q.push_back(32'h2 | 32'(((n / 4) % 2)));
      sb_check($sformatf("blink STATUS n=%0d", n), readdata);
    end
    bus_read(ADDR_PRESCALE, 32'h3, "PRESCALE readback");
    bus_read(ADDR_MODE, 32'h1, "MODE readback");

    // Reset mid-blink
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("async reset out_port", 32'(out_port), 32'(RV));
    address = ADDR_STATUS;
    #1;
    check_eq("in-reset STATUS", readdata, 32'h2);
    @(negedge clk);
    reset_n = 1'b1;
    m_out   = RV;
    repeat (3) @(posedge clk);
    #1;
    check_eq("post-reset2 out_port", 32'(out_port), 32'(RV));
    bus_read(ADDR_STATUS, 32'h2, "post-reset2 STATUS");
    bus_read(ADDR_PRESCALE, 32'h00FF_FFFF, "post-reset2 PRESCALE");

`ifdef NIOS_CORE_PIO_PWM_EN
    // PWM duty sweep
    bus_write(ADDR_DUTY, 32'd64);
    bus_write(ADDR_DATA, 32'hFFFF);
    bus_read(ADDR_DUTY, 32'h40, "DUTY readback");
    repeat (2) @(posedge clk);
    count_cycles(255, hi, lo);
    exp_q.push_back(32'd64);
    sb_check("duty64 on", 32'(hi));
    exp_q.push_back(32'd191);
    sb_check("duty64 off", 32'(lo));
    bus_write(ADDR_DUTY, 32'd0);
    repeat (2) @(posedge clk);
    count_cycles(255, hi, lo);
    exp_q.push_back(32'd255);
    sb_check("duty0 off", 32'(lo));
    bus_read(ADDR_STATUS, 32'h0, "duty0 STATUS");
    bus_write(ADDR_DUTY, 32'd255);
    repeat (2) @(posedge clk);
    count_cycles(255, hi, lo);
    exp_q.push_back(32'd255);
    sb_check("duty255 on", 32'(hi));
`else
    // DUTY is absent: address 2 reads 0 and writes have no effect
    bus_write(ADDR_DUTY, 32'h10);
    bus_read(ADDR_DUTY, 32'h0, "no-PWM DUTY read");
    bus_write(ADDR_DATA, 32'hFFFF);
    repeat (2) @(posedge clk);
    count_cycles(40, hi, lo);
    exp_q.push_back(32'd40);
    sb_check("no-PWM always on", 32'(hi));
    bus_read(ADDR_STATUS, 32'h2, "no-PWM STATUS");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
